// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states,
// opcode/funct constants and ALU control codes.
package mips_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiExec = 4'd9,
        StAddiWb   = 4'd10,
        StJump     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } aluop_t;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's aluop and the R-type funct field to an
// ALU operation code.
module aludec
    import mips_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        alucontrol = AluAdd;
        unique case (aluop)
            AluOpAdd: alucontrol = AluAdd;
            AluOpSub: alucontrol = AluSub;
            AluOpFunct: begin
                case (funct)
                    FunctAdd: alucontrol = AluAdd;
                    FunctSub: alucontrol = AluSub;
                    FunctAnd: alucontrol = AluAnd;
                    FunctOr:  alucontrol = AluOr;
                    FunctSlt: alucontrol = AluSlt;
                    default:  alucontrol = AluAdd;
                endcase
            end
            default: alucontrol = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode and
// per-instruction datapath control, plus the ALU decoder.
module mc_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        memwrite,
    output logic        irwrite,
    output logic        pcen,
    output logic        iord,
    output logic        alusrcA,
    output logic [1:0]  alusrcB,
    output logic [1:0]  pcsrc,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        jump,
    output logic [2:0]  alucontrol,
    output logic [3:0]  state
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd:    state_d = StMemWb;
            StExecute:  state_d = StAluWb;
            StAddiExec: state_d = StAddiWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        alusrcA  = 1'b0;
        alusrcB  = 2'b00;
        pcsrc    = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        jump     = 1'b0;
        aluop    = AluOpAdd;
        unique case (state_q)
            StFetch: begin
                alusrcB = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            StDecode: alusrcB = 2'b11;
            StMemAdr, StAddiExec: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
            end
            StMemRd: iord = 1'b1;
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StAddiWb: regwrite = 1'b1;
            StExecute: begin
                alusrcA = 1'b1;
                aluop   = AluOpFunct;
            end
            StBranch: begin
                alusrcA = 1'b1;
                aluop   = AluOpSub;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            StJump: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                jump    = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction scenarios plus a randomized
// instruction stream checked against a path/output table model.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite, irwrite, pcen, iord, alusrcA;
    logic [1:0] alusrcB, pcsrc;
    logic       regwrite, regdst, memtoreg, jump;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic [15:0] dut_vec;

    int n_pass;
    int n_total;

    localparam logic [15:0] FetchVec = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00,
                                        1'b0, 1'b0, 1'b0, 1'b0, 3'b010};

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .iord       (iord),
        .alusrcA    (alusrcA),
        .alusrcB    (alusrcB),
        .pcsrc      (pcsrc),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .jump       (jump),
        .alucontrol (alucontrol),
        .state      (state)
    );

    assign dut_vec = {memwrite, irwrite, pcen, iord, alusrcA, alusrcB, pcsrc,
                      regwrite, regdst, memtoreg, jump, alucontrol};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: the state path each opcode takes, starting from FETCH.
    function automatic int path_len(input logic [5:0] o);
        case (o)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic int path_state(input logic [5:0] o, input int i);
        int p[5];
        p = '{0, 1, 0, 0, 0};
        case (o)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5, 0};
            6'b000000: p = '{0, 1, 6, 7, 0};
            6'b000100: p = '{0, 1, 8, 0, 0};
            6'b001000: p = '{0, 1, 9, 10, 0};
            6'b000010: p = '{0, 1, 11, 0, 0};
            default:   p = '{0, 1, 0, 0, 0};
        endcase
        return p[i];
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int st, input logic [5:0] f, input logic z);
        logic mw, ir, pw, br, io, sa, rw, rd, mr, jp;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {mw, ir, pw, br, io, sa, rw, rd, mr, jp} = '0;
        sb = 2'b00;
        ps = 2'b00;
        ac = 3'b010;
        case (st)
            0:     begin ir = 1'b1; pw = 1'b1; sb = 2'b01; end
            1:     sb = 2'b11;
            2, 9:  begin sa = 1'b1; sb = 2'b10; end
            3:     io = 1'b1;
            4:     begin rw = 1'b1; mr = 1'b1; end
            5:     begin io = 1'b1; mw = 1'b1; end
            6:     begin sa = 1'b1; ac = funct_alu(f); end
            7:     begin rw = 1'b1; rd = 1'b1; end
            8:     begin sa = 1'b1; ac = 3'b110; ps = 2'b01; br = 1'b1; end
            10:    rw = 1'b1;
            11:    begin ps = 2'b10; pw = 1'b1; jp = 1'b1; end
            default: ;
        endcase
        return {mw, ir, pw | (br & z), io, sa, sb, ps, rw, rd, mr, jp, ac};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op    = 6'b111111;
        funct = 6'b000000;
        zero  = 1'b0;
        step();
        n_total++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state);
        else n_pass++;
        n_total++;
        if (dut_vec !== FetchVec) $display("FAIL reset_outputs: got %h want %h", dut_vec, FetchVec);
        else n_pass++;
        reset = 1'b1;
        step();
        n_total++;
        if (state !== 4'd1) $display("FAIL reset_first_edge: got %0d want 1", state);
        else n_pass++;
        step();
    endtask

    task automatic test_lw();
        int want[5];
        want = '{0, 1, 2, 3, 4};
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (state !== 4'(want[i])) $display("FAIL lw_state%0d: got %0d want %0d", i, state, want[i]);
            else n_pass++;
            if (i == 3) begin
                n_total++;
                if (iord !== 1'b1) $display("FAIL lw_memrd_iord: got %b want 1", iord);
                else n_pass++;
            end
            if (i == 4) begin
                n_total++;
                if ({regwrite, memtoreg, regdst} !== 3'b110)
                    $display("FAIL lw_memwb: got %b want 110", {regwrite, memtoreg, regdst});
                else n_pass++;
            end
            step();
        end
        n_total++;
        if (state !== 4'd0) $display("FAIL lw_return: got %0d want 0", state);
        else n_pass++;
    endtask

    task automatic test_slt();
        op    = 6'b000000;
        funct = 6'b101010;
        step();
        step();
        n_total++;
        if ({state, alucontrol, alusrcA, alusrcB} !== {4'd6, 3'b111, 1'b1, 2'b00})
            $display("FAIL slt_execute: got st=%0d alu=%b a=%b b=%b want st=6 alu=111 a=1 b=00",
                     state, alucontrol, alusrcA, alusrcB);
        else n_pass++;
        step();
        n_total++;
        if ({state, regwrite, regdst} !== {4'd7, 1'b1, 1'b1})
            $display("FAIL slt_aluwb: got st=%0d rw=%b rd=%b want st=7 rw=1 rd=1",
                     state, regwrite, regdst);
        else n_pass++;
        step();
    endtask

    task automatic test_beq();
        op   = 6'b000100;
        zero = 1'b1;
        step();
        step();
        n_total++;
        if ({state, pcen, pcsrc, alucontrol} !== {4'd8, 1'b1, 2'b01, 3'b110})
            $display("FAIL beq_taken: got st=%0d pcen=%b pcsrc=%b alu=%b want 8 1 01 110",
                     state, pcen, pcsrc, alucontrol);
        else n_pass++;
        zero = 1'b0;
        #1;
        n_total++;
        if (pcen !== 1'b0) $display("FAIL beq_not_taken: got pcen=%b want 0", pcen);
        else n_pass++;
        step();
        n_total++;
        if (state !== 4'd0) $display("FAIL beq_return: got %0d want 0", state);
        else n_pass++;
    endtask

    task automatic test_jump();
        op = 6'b000010;
        step();
        step();
        n_total++;
        if ({state, pcen, pcsrc, jump} !== {4'd11, 1'b1, 2'b10, 1'b1})
            $display("FAIL j_state: got st=%0d pcen=%b pcsrc=%b jump=%b want 11 1 10 1",
                     state, pcen, pcsrc, jump);
        else n_pass++;
        step();
        n_total++;
        if (state !== 4'd0) $display("FAIL j_return: got %0d want 0", state);
        else n_pass++;
    endtask

    task automatic test_illegal();
        op = 6'b111111;
        step();
        n_total++;
        if ({state, regwrite, memwrite} !== {4'd1, 1'b0, 1'b0})
            $display("FAIL illegal_decode: got st=%0d rw=%b mw=%b want 1 0 0",
                     state, regwrite, memwrite);
        else n_pass++;
        step();
        n_total++;
        if ({state, regwrite, memwrite} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL illegal_return: got st=%0d rw=%b mw=%b want 0 0 0",
                     state, regwrite, memwrite);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        op = 6'b101011;
        step();
        step();
        n_total++;
        if (state !== 4'd2) $display("FAIL sw_memadr: got %0d want 2", state);
        else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_total++;
        if (state !== 4'd0) $display("FAIL async_reset_state: got %0d want 0", state);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (dut_vec !== FetchVec)
                $display("FAIL async_reset_hold%0d: got %h want %h", i, dut_vec, FetchVec);
            else n_pass++;
            step();
        end
        #3 reset = 1'b1;
        step();
        n_total++;
        if ({state, memwrite} !== {4'd1, 1'b0})
            $display("FAIL async_reset_release: got st=%0d mw=%b want 1 0", state, memwrite);
        else n_pass++;
        op = 6'b111111;
        step();
    endtask

    task automatic test_random(input int count);
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        logic [5:0] o, f;
        logic       z;
        int         n;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int k = 0; k < count; k++) begin
            o = ops[$urandom_range(6)];
            if ($urandom_range(7) == 0) o = 6'($urandom);
            f = fns[$urandom_range(5)];
            if (f == 6'b000000) f = 6'($urandom);
            z = 1'($urandom);
            op    = o;
            funct = f;
            zero  = z;
            n = path_len(o);
            for (int i = 0; i < n; i++) begin
                n_total++;
                if (state !== 4'(path_state(o, i)))
                    $display("FAIL rand%0d_state op=%b step%0d: got %0d want %0d",
                             k, o, i, state, path_state(o, i));
                else n_pass++;
                n_total++;
                if (dut_vec !== exp_out(path_state(o, i), f, z))
                    $display("FAIL rand%0d_outputs op=%b f=%b step%0d: got %h want %h",
                             k, o, f, i, dut_vec, exp_out(path_state(o, i), f, z));
                else n_pass++;
                step();
            end
            n_total++;
            if (state !== 4'd0) $display("FAIL rand%0d_latency op=%b: got %0d want 0", k, o, state);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_lw();
        test_slt();
        test_beq();
        test_jump();
        test_illegal();
        test_async_reset();
        test_random(200);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL use a single clock and asynchronous active-low reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-low (0 = reset).
REQ-002 op  input  6  instr[31:26] from the instruction register.
REQ-003 funct  input  6  instr[5:0] from the instruction register.
REQ-004 zero  input  1  ALU zero flag.
REQ-005 memwrite  output  1  data memory write strobe.
REQ-006 irwrite  output  1  instruction register load enable.
REQ-007 pcen  output  1  PC register load enable.
REQ-008 iord  output  1  memory address select (0 = pc, 1 = aluout).
REQ-009 alusrcA  output  1  ALU A select (0 = pc, 1 = A reg).
REQ-010 alusrcB  output  2  ALU B select (00 = B reg, 01 = 4, 10 = signimm, 11 = signimm<<2).
REQ-011 pcsrc  output  2  next-PC select (00 = aluresult, 01 = aluout, 10 = jump target).
REQ-012 regwrite, regdst, memtoreg, jump  output  1 each  register-file write, dest select (1 = rd), writeback select (1 = memory data), jump-state flag.
REQ-013 alucontrol  output  3  ALU operation.
REQ-014 state  output  4  current FSM state, for debug and verification.

Function
REQ-015 Moore FSM: all outputs SHALL be decoded from the current state only, except pcen = pcwrite | (branch & zero).
REQ-016 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-017 Transitions:
- FETCH->DECODE.
- DECODE: lw(100011)/sw(101011)->MEMADR; R-type(000000)->EXECUTE; beq(000100)->BRANCH; addi(001000)->ADDIEXEC; j(000010)->JUMP; any other op->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB.
- EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
- Codes 12-15 SHALL go to FETCH.
REQ-018 FETCH: iord=0, alusrcA=0, alusrcB=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1.
REQ-019 DECODE: alusrcA=0, alusrcB=11, aluop=add; no write strobes.
REQ-020 MEMADR/ADDIEXEC: alusrcA=1, alusrcB=10, aluop=add.
REQ-021 MEMRD: iord=1.
REQ-022 MEMWR: iord=1, memwrite=1.
REQ-023 MEMWB: regdst=0, memtoreg=1, regwrite=1.
REQ-024 ALUWB: regdst=1, memtoreg=0, regwrite=1.
REQ-025 ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-026 EXECUTE: alusrcA=1, alusrcB=00, aluop=funct.
REQ-027 BRANCH: alusrcA=1, alusrcB=00, aluop=sub, pcsrc=01, branch=1.
REQ-028 JUMP: pcsrc=10, pcwrite=1, jump=1.
REQ-029 Every signal not listed for a state SHALL be 0.
REQ-030 ALU decode (aluop 2 bits: 00 add, 01 sub, 10 funct): add=010, sub=110. Funct table: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; unlisted funct->010.
REQ-031 Instruction latency: lw 5 cycles; sw, R-type, addi 4; beq, j 3; illegal op 2.

Reset
REQ-032 reset=0 SHALL force state=FETCH immediately, independent of clk, including mid-instruction.
REQ-033 While reset=0, outputs SHALL equal FETCH decode: irwrite=1, pcen=1, alusrcB=01, alucontrol=010, all else 0.
REQ-034 The first rising clk after reset deasserts SHALL move the FSM to DECODE.

Structure
REQ-035 State enum, opcode/funct constants and alucontrol codes SHALL live in shared package mips_pkg.
REQ-036 The ALU decoder SHALL be a separate combinational sub-module aludec (aluop, funct -> alucontrol), instantiated once.

Verification
REQ-037 lw (op=100011): states 0,1,2,3,4 over 5 cycles; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1; back to 0.
REQ-038 R-type slt (funct=101010): EXECUTE alucontrol=111, alusrcA=1, alusrcB=00; ALUWB regwrite=1, regdst=1.
REQ-039 beq with zero=1 in BRANCH: pcen=1, pcsrc=01, alucontrol=110. Same with zero=0: pcen=0.
REQ-040 j (op=000010): JUMP pcen=1, pcsrc=10, jump=1; next state FETCH.
REQ-041 Illegal op=111111: DECODE->FETCH with no regwrite or memwrite pulse.
REQ-042 reset pulled low asynchronously during sw MEMADR: state=0 before next clk edge; memwrite never asserted.
